// File: rtl/gshare_pattern_history_table.sv
// ---------------------------------------------------------------------------
// gshare_pattern_history_table
//
// Gshare branch direction predictor. The fetch PC index is XORed with a
// speculative global history register (GHR) to select one of 2**INDEX_W
// saturating counters; the counter MSB is the predicted direction. The hashed
// index and the GHR snapshot used for the prediction are returned so they can
// travel with the branch and come back at resolution time for training and,
// on a mispredict, for rolling the GHR back.
//
// Ports
//   clk             clock, all state updates on the rising edge
//   rst             asynchronous reset, active-high
//   stall           holds counters, GHR and mispredict_cnt when 1
//   pred_valid      fetch presents a conditional branch this cycle
//   pred_pc_idx     PC index bits of the fetched instruction
//   pred_taken      predicted direction (combinational)
//   pred_idx        hashed table index used (combinational)
//   pred_ghr        GHR value used for this prediction (combinational)
//   upd_valid       a conditional branch resolves this cycle
//   upd_idx         pred_idx carried with the resolving branch
//   upd_ghr         pred_ghr carried with the resolving branch
//   upd_taken       actual branch outcome
//   upd_mispredict  resolved direction differs from prediction
//   mispredict_cnt  saturating count of accepted mispredicts
// ---------------------------------------------------------------------------
module gshare_pattern_history_table #(
  parameter int INDEX_W  = 4,
  parameter int CTR_W    = 2,
  parameter int GHR_W    = 4,
  parameter int INIT_CTR = 2**CTR_W-1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               pred_valid,
  input  logic [INDEX_W-1:0] pred_pc_idx,
  output logic               pred_taken,
  output logic [INDEX_W-1:0] pred_idx,
  output logic [GHR_W-1:0]   pred_ghr,
  input  logic               upd_valid,
  input  logic [INDEX_W-1:0] upd_idx,
  input  logic [GHR_W-1:0]   upd_ghr,
  input  logic               upd_taken,
  input  logic               upd_mispredict,
  output logic [15:0]        mispredict_cnt
);

  localparam int               ENTRIES  = 2**INDEX_W;
  localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(INIT_CTR);

  logic [CTR_W-1:0]   ctr [ENTRIES];
  logic [GHR_W-1:0]   ghr;
  logic [GHR_W-1:0]   ghr_spec;
  logic [GHR_W-1:0]   ghr_recov;
  logic [INDEX_W-1:0] ghr_ext;
  logic               accept_upd;
  logic               accept_mispred;
  logic               accept_pred;

  // Two-direction saturating step of a prediction counter.
  function automatic logic [CTR_W-1:0] ctr_train(input logic [CTR_W-1:0] c,
                                                 input logic             taken);
    logic [CTR_W-1:0] r;
    r = c;
    if (taken) begin
      if (c != CTR_MAX) r = c + CTR_W'(1);
    end else begin
      if (c != '0) r = c - CTR_W'(1);
    end
    return r;
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] cnt_sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  assign accept_upd     = upd_valid & ~stall;
  assign accept_mispred = upd_valid & upd_mispredict & ~stall;
  assign accept_pred    = pred_valid & ~stall;

  // History is shorter than (or equal to) the index; it only folds into the
  // low bits of the PC index.
  assign ghr_ext    = INDEX_W'(ghr);
  assign pred_idx   = pred_pc_idx ^ ghr_ext;
  assign pred_ghr   = ghr;
  // Read before any same-cycle training write: no bypass by design.
  assign pred_taken = ctr[pred_idx][CTR_W-1];

  // Next GHR values. With a one-bit history there is nothing to shift, so the
  // new outcome simply replaces it.
  if (GHR_W == 1) begin : g_ghr_one
    logic upd_ghr_unused;
    assign upd_ghr_unused = upd_ghr[0];
    assign ghr_spec       = pred_taken;
    assign ghr_recov      = upd_taken;
  end else begin : g_ghr_multi
    // The oldest bit of the snapshot falls off the end when the resolved
    // outcome is appended.
    logic upd_ghr_msb_unused;
    assign upd_ghr_msb_unused = upd_ghr[GHR_W-1];
    assign ghr_spec           = {ghr[GHR_W-2:0], pred_taken};
    assign ghr_recov          = {upd_ghr[GHR_W-2:0], upd_taken};
  end

  // Speculative history; a resolving mispredict overrides a same-cycle shift
  // because the fetched branch is on the wrong path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr <= '0;
    end else if (accept_mispred) begin
      ghr <= ghr_recov;
    end else if (accept_pred) begin
      ghr <= ghr_spec;
    end
  end

  // Counter training, applied on every resolution regardless of correctness.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr[i] <= CTR_INIT;
      end
    end else if (accept_upd) begin
      ctr[upd_idx] <= ctr_train(ctr[upd_idx], upd_taken);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mispredict_cnt <= '0;
    end else if (accept_mispred) begin
      mispredict_cnt <= cnt_sat_inc(mispredict_cnt);
    end
  end

endmodule

// File: tb/tb_gshare_pattern_history_table.sv
module tb_gshare_pattern_history_table;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        pred_valid;
  logic [3:0]  pred_pc_idx;
  logic        pred_taken;
  logic [3:0]  pred_idx;
  logic [3:0]  pred_ghr;
  logic        upd_valid;
  logic [3:0]  upd_idx;
  logic [3:0]  upd_ghr;
  logic        upd_taken;
  logic        upd_mispredict;
  logic [15:0] mispredict_cnt;

  gshare_pattern_history_table #(
    .INDEX_W (4),
    .CTR_W   (2),
    .GHR_W   (4),
    .INIT_CTR(3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .pred_valid    (pred_valid),
    .pred_pc_idx   (pred_pc_idx),
    .pred_taken    (pred_taken),
    .pred_idx      (pred_idx),
    .pred_ghr      (pred_ghr),
    .upd_valid     (upd_valid),
    .upd_idx       (upd_idx),
    .upd_ghr       (upd_ghr),
    .upd_taken     (upd_taken),
    .upd_mispredict(upd_mispredict),
    .mispredict_cnt(mispredict_cnt)
  );

  always #5 clk = ~clk;

  // Observed tuple: {pred_taken, pred_idx, pred_ghr, mispredict_cnt}
  typedef struct packed {
    logic        taken;
    logic [3:0]  idx;
    logic [3:0]  ghr;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  logic [1:0]  m_ctr [16];
  logic [3:0]  m_ghr;
  logic [15:0] m_cnt;

  function automatic exp_t model_expect();
    exp_t e;
    logic [3:0] ix;
    ix      = pred_pc_idx ^ m_ghr;
    e.taken = m_ctr[ix][1];
    e.idx   = ix;
    e.ghr   = m_ghr;
    e.cnt   = m_cnt;
    return e;
  endfunction

  function automatic exp_t observed();
    return {pred_taken, pred_idx, pred_ghr, mispredict_cnt};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_ctr[i] = 2'd3;
    m_ghr = 4'd0;
    m_cnt = 16'd0;
  endtask

  task automatic idle_inputs();
    stall          = 1'b0;
    pred_valid     = 1'b0;
    upd_valid      = 1'b0;
    upd_idx        = 4'd0;
    upd_ghr        = 4'd0;
    upd_taken      = 1'b0;
    upd_mispredict = 1'b0;
  endtask

  // Advance one rising edge and apply the same edge to the model.
  task automatic step();
    logic pt;
    @(posedge clk);
    if (!rst && !stall) begin
      pt = m_ctr[pred_pc_idx ^ m_ghr][1];
      if (upd_valid) begin
        if (upd_taken) begin
          if (m_ctr[upd_idx] != 2'd3) m_ctr[upd_idx] = m_ctr[upd_idx] + 2'd1;
        end else begin
          if (m_ctr[upd_idx] != 2'd0) m_ctr[upd_idx] = m_ctr[upd_idx] - 2'd1;
        end
      end
      if (upd_valid && upd_mispredict) begin
        m_ghr = {upd_ghr[2:0], upd_taken};
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end else if (pred_valid) begin
        m_ghr = {m_ghr[2:0], pt};
      end
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    exp_t got;
    idle_inputs();
    pred_pc_idx = 4'h5;
    rst = 1'b1;
    model_reset();
    #2;
    exp_q.push_back(exp_t'({1'b1, 4'h5, 4'h0, 16'h0000}));
    e = exp_q.pop_front();
    got = observed();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL reset_state got %h required %h", got, e);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_train_saturate();
    exp_t e;
    exp_t got;
    @(negedge clk);
    pred_pc_idx = 4'h3;
    upd_valid   = 1'b1;
    upd_idx     = 4'h3;
    upd_taken   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(model_expect());
      #1;
      e = exp_q.pop_front();
      got = observed();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL train_dec[%0d] got %h required %h", i, got, e);
      end
      step();
      @(negedge clk);
    end
    upd_valid = 1'b0;
    #1;
    checks++;
    if (pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL train_sat_zero pred_taken got %b required 0", pred_taken);
    end
  endtask

  task automatic test_ghr_shift();
    exp_t e;
    exp_t got;
    logic [3:0] pcs [4];
    logic       dirs [4];
    pcs[0] = 4'h0; pcs[1] = 4'h9; pcs[2] = 4'h0; pcs[3] = 4'h0;
    dirs[0] = 1'b1; dirs[1] = 1'b0; dirs[2] = 1'b1; dirs[3] = 1'b1;
    do_reset();
    // Drive entry 8 down to 1 so it predicts not-taken.
    upd_valid = 1'b1;
    upd_idx   = 4'h8;
    upd_taken = 1'b0;
    step();
    step();
    @(negedge clk);
    upd_valid  = 1'b0;
    pred_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pred_pc_idx = pcs[i];
      exp_q.push_back(model_expect());
      #1;
      e = exp_q.pop_front();
      got = observed();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL ghr_shift[%0d] got %h required %h", i, got, e);
      end
      checks++;
      if (pred_taken !== dirs[i]) begin
        errors++;
        $display("FAIL ghr_dir[%0d] pred_taken got %b required %b", i, pred_taken, dirs[i]);
      end
      step();
      @(negedge clk);
    end
    pred_valid  = 1'b0;
    pred_pc_idx = 4'h0;
    #1;
    checks++;
    if ({pred_ghr, pred_idx} !== 8'hBB) begin
      errors++;
      $display("FAIL ghr_value ghr/idx got %h/%h required b/b", pred_ghr, pred_idx);
    end
  endtask

  task automatic test_recovery();
    exp_t e;
    exp_t got;
    @(negedge clk);
    pred_valid     = 1'b1;
    pred_pc_idx    = 4'h0;
    upd_valid      = 1'b1;
    upd_mispredict = 1'b1;
    upd_ghr        = 4'b0010;
    upd_taken      = 1'b1;
    upd_idx        = 4'h4;
    exp_q.push_back(model_expect());
    #1;
    e = exp_q.pop_front();
    got = observed();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL recovery_pre got %h required %h", got, e);
    end
    step();
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if ({pred_ghr, mispredict_cnt} !== {4'b0101, 16'd1}) begin
      errors++;
      $display("FAIL recovery ghr/cnt got %b/%0d required 0101/1", pred_ghr, mispredict_cnt);
    end
  endtask

  task automatic test_stall();
    exp_t e;
    exp_t got;
    @(negedge clk);
    stall          = 1'b1;
    pred_valid     = 1'b1;
    pred_pc_idx    = 4'h3;
    upd_valid      = 1'b1;
    upd_idx        = 4'h6;
    upd_taken      = 1'b0;
    upd_mispredict = 1'b1;
    upd_ghr        = 4'h0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(model_expect());
      #1;
      e = exp_q.pop_front();
      got = observed();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL stall_hold[%0d] got %h required %h", i, got, e);
      end
      checks++;
      if ({pred_taken, pred_ghr, mispredict_cnt} !== {1'b1, 4'b0101, 16'd1}) begin
        errors++;
        $display("FAIL stall_const[%0d] got %b/%b/%0d required 1/0101/1",
                 i, pred_taken, pred_ghr, mispredict_cnt);
      end
      if (i < 2) begin
        step();
        @(negedge clk);
      end
    end
    stall = 1'b0;
    step();
    @(negedge clk);
    idle_inputs();
    pred_pc_idx = 4'h6;
    exp_q.push_back(model_expect());
    #1;
    e = exp_q.pop_front();
    got = observed();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL stall_release got %h required %h", got, e);
    end
    checks++;
    if ({pred_ghr, mispredict_cnt} !== {4'b0000, 16'd2}) begin
      errors++;
      $display("FAIL stall_once ghr/cnt got %b/%0d required 0000/2", pred_ghr, mispredict_cnt);
    end
  endtask

  task automatic test_same_cycle();
    exp_t e;
    exp_t got;
    do_reset();
    upd_valid = 1'b1;
    upd_idx   = 4'h7;
    upd_taken = 1'b0;
    step();
    @(negedge clk);
    pred_pc_idx = 4'h7;
    exp_q.push_back(model_expect());
    #1;
    e = exp_q.pop_front();
    got = observed();
    checks++;
    if (got !== e || pred_taken !== 1'b1) begin
      errors++;
      $display("FAIL same_cycle_pre got %h required %h", got, e);
    end
    step();
    @(negedge clk);
    upd_valid = 1'b0;
    #1;
    checks++;
    if (pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle_post pred_taken got %b required 0", pred_taken);
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    exp_t got;
    do_reset();
    upd_valid      = 1'b1;
    upd_mispredict = 1'b1;
    upd_taken      = 1'b0;
    upd_idx        = 4'h0;
    upd_ghr        = 4'hF;
    pred_pc_idx    = 4'h0;
    step();
    @(negedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    exp_q.push_back(exp_t'({1'b1, 4'h0, 4'h0, 16'h0000}));
    e = exp_q.pop_front();
    got = observed();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL async_reset got %h required %h", got, e);
    end
    step();
    @(negedge clk);
    rst = 1'b0;
    step();
    exp_q.push_back(model_expect());
    e = exp_q.pop_front();
    got = observed();
    checks++;
    if (got !== e || mispredict_cnt !== 16'd1) begin
      errors++;
      $display("FAIL post_reset_update got %h required %h", got, e);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    exp_t got;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      stall          = ($urandom_range(9) == 0);
      pred_valid     = 1'($urandom_range(1));
      pred_pc_idx    = 4'($urandom_range(15));
      upd_valid      = 1'($urandom_range(1));
      upd_idx        = 4'($urandom_range(15));
      upd_ghr        = 4'($urandom_range(15));
      upd_taken      = 1'($urandom_range(1));
      upd_mispredict = ($urandom_range(3) == 0);
      exp_q.push_back(model_expect());
      #1;
      e = exp_q.pop_front();
      got = observed();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL random[%0d] got %h required %h", i, got, e);
      end
      step();
    end
    @(negedge clk);
    idle_inputs();
    exp_q.push_back(model_expect());
    #1;
    e = exp_q.pop_front();
    got = observed();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL random_final got %h required %h", got, e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_train_saturate();
    test_ghr_shift();
    test_recovery();
    test_stall();
    test_same_cycle();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
